// File: rtl/rvvi_stream_packetizer_if.sv
// AXI-Stream-style beat channel between the rvvi packetizer and the trace transmitter.
interface rvvi_stream_packetizer_if #(
  parameter int BEAT_W = 32
);
  logic [BEAT_W-1:0]   TData;
  logic [BEAT_W/8-1:0] TKeep;
  logic                TLast;
  logic                TValid;
  logic                TReady;

  modport master (output TData, TKeep, TLast, TValid, input TReady);
  modport slave  (input TData, TKeep, TLast, TValid, output TReady);
endinterface

// File: rtl/rvvi_stream_packetizer.sv
// Buffers compressed rvvi records in a small FIFO and serialises each one as a
// variable-length beat burst carrying only the populated CSR slots.
module rvvi_stream_packetizer #(
  parameter int XLEN     = 64,
  parameter int MAX_CSRS = 3,
  parameter int BEAT_W   = 32,
  parameter int DEPTH    = 4,
  parameter int RVVI_W   = 3*XLEN+200+MAX_CSRS*(XLEN+16)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   En,
  input  logic                   valid,
  input  logic [RVVI_W-1:0]      rvvi,
  output logic                   RvviStall,
  rvvi_stream_packetizer_if.master axis,
  output logic [15:0]            DropCount,
  output logic                   Overflow,
  input  logic                   ClearOverflow
);

  localparam int BASE_W = 3*XLEN+200;
  localparam int SLOT_W = XLEN+16;
  localparam int MAXB   = (RVVI_W+BEAT_W-1)/BEAT_W;
  localparam int PAD_W  = MAXB*BEAT_W;
  localparam int KW     = BEAT_W/8;
  localparam int BCW    = $clog2(MAXB+1);
  localparam int PW     = $clog2(DEPTH);
  localparam int OCW    = PW+1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [PAD_W-1:0] rec_mem_q  [DEPTH];
  logic [PAD_W-1:0] rec_mem_d  [DEPTH];
  logic [BCW-1:0]   beat_mem_q [DEPTH];
  logic [BCW-1:0]   beat_mem_d [DEPTH];
  logic [KW-1:0]    keep_mem_q [DEPTH];
  logic [KW-1:0]    keep_mem_d [DEPTH];

  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCW-1:0] occ_q, occ_d;
  logic [0:0]     state_q, state_d;
  logic [BCW-1:0] idx_q, idx_d;
  logic [15:0]    drop_q, drop_d;
  logic           ovf_q, ovf_d;

  logic [31:0]    csr_n, rec_len, rem_w, last_bytes;
  logic [PAD_W-1:0] push_rec;
  logic [BCW-1:0] push_beats;
  logic [KW-1:0]  push_keep;

  logic full, empty, last_beat, hs, push, pop, drop;
  logic [PAD_W-1:0] head_rec;
  logic [BCW-1:0]   head_beats;
  logic [KW-1:0]    head_keep;

  // Record length derives from the clamped CSR count; bits past it are zeroed on entry.
  always_comb begin
    csr_n = 32'(rvvi[XLEN+179:XLEN+168]);
    if (csr_n > 32'(MAX_CSRS)) csr_n = 32'(MAX_CSRS);
    rec_len    = 32'(BASE_W) + csr_n * 32'(SLOT_W);
    push_beats = BCW'((rec_len + 32'(BEAT_W-1)) / 32'(BEAT_W));
    rem_w      = rec_len % 32'(BEAT_W);
    last_bytes = (rem_w == 32'd0) ? 32'(KW) : rem_w / 32'd8;
    push_keep  = '0;
    for (int unsigned k = 0; k < KW; k++) push_keep[k] = (k < last_bytes);
    push_rec = PAD_W'(rvvi);
    for (int unsigned i = 0; i < PAD_W; i++) begin
      if (i >= rec_len) push_rec[i] = 1'b0;
    end
  end

  assign head_rec   = rec_mem_q[rd_ptr_q];
  assign head_beats = beat_mem_q[rd_ptr_q];
  assign head_keep  = keep_mem_q[rd_ptr_q];

  assign full      = (occ_q == OCW'(DEPTH));
  assign empty     = (occ_q == '0);
  assign last_beat = ((idx_q + BCW'(1)) == head_beats);
  assign hs        = (state_q == S_SEND) && axis.TReady;
  assign pop       = hs && last_beat;
  assign push      = En && valid && (!full || pop);
  assign drop      = En && valid && full && !pop;

  always_comb begin
    rec_mem_d  = rec_mem_q;
    beat_mem_d = beat_mem_q;
    keep_mem_d = keep_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    state_d    = state_q;
    idx_d      = idx_q;
    drop_d     = drop_q;
    ovf_d      = ovf_q;

    if (push) begin
      rec_mem_d[wr_ptr_q]  = push_rec;
      beat_mem_d[wr_ptr_q] = push_beats;
      keep_mem_d[wr_ptr_q] = push_keep;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push, pop})
      2'b10:   occ_d = occ_q + OCW'(1);
      2'b01:   occ_d = occ_q - OCW'(1);
      default: occ_d = occ_q;
    endcase

    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (!empty) state_d = S_SEND;
      end
      default: begin
        if (hs) begin
          if (last_beat) begin
            idx_d = '0;
            // A same-cycle push keeps the burst train going without a bubble.
            if (occ_d == '0) state_d = S_IDLE;
          end else begin
            idx_d = idx_q + BCW'(1);
          end
        end
      end
    endcase

    if (ClearOverflow) begin
      drop_d = '0;
      ovf_d  = 1'b0;
    end else if (drop) begin
      if (drop_q != '1) drop_d = drop_q + 16'd1;
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    rec_mem_q  <= rec_mem_d;
    beat_mem_q <= beat_mem_d;
    keep_mem_q <= keep_mem_d;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      state_q  <= S_IDLE;
      idx_q    <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      state_q  <= state_d;
      idx_q    <= idx_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    axis.TValid = 1'b0;
    axis.TData  = '0;
    axis.TKeep  = '0;
    axis.TLast  = 1'b0;
    if (state_q == S_SEND) begin
      axis.TValid = 1'b1;
      axis.TData  = head_rec[32'(idx_q)*BEAT_W +: BEAT_W];
      axis.TKeep  = last_beat ? head_keep : '1;
      axis.TLast  = last_beat;
    end
  end

  assign RvviStall = (occ_q >= OCW'(DEPTH-1));
  assign DropCount = drop_q;
  assign Overflow  = ovf_q;

endmodule

// File: tb/tb_rvvi_stream_packetizer.sv
// Scoreboard bench: a cycle-level queue model predicts acceptance, drops and beats;
// a negedge monitor compares every handshaked beat against the expected stream.
module tb_rvvi_stream_packetizer;
  localparam int XLEN     = 64;
  localparam int MAX_CSRS = 3;
  localparam int BEAT_W   = 32;
  localparam int DEPTH    = 4;
  localparam int RVVI_W   = 3*XLEN+200+MAX_CSRS*(XLEN+16);

  typedef struct {
    logic [BEAT_W-1:0]   data;
    logic [BEAT_W/8-1:0] keep;
    logic                last;
  } beat_t;

  logic clk = 1'b0;
  logic resetn, en, valid, clr, tready;
  logic [RVVI_W-1:0] rvvi;
  logic stall, ovf;
  logic [15:0] drop_cnt;

  rvvi_stream_packetizer_if #(.BEAT_W(BEAT_W)) axis ();
  assign axis.TReady = tready;

  rvvi_stream_packetizer #(
    .XLEN(XLEN), .MAX_CSRS(MAX_CSRS), .BEAT_W(BEAT_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .resetn(resetn), .En(en), .valid(valid), .rvvi(rvvi),
    .RvviStall(stall), .axis(axis), .DropCount(drop_cnt), .Overflow(ovf),
    .ClearOverflow(clr)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  beat_t sb[$];

  // reference model: records held in the DUT (beat counts), burst progress, drop state
  int m_q[$];
  bit m_send = 1'b0;
  int m_beat = 0;
  int m_dc = 0;
  bit m_ov = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [RVVI_W-1:0] make_rec(int csr);
    logic [RVVI_W-1:0] r;
    for (int i = 0; i < RVVI_W; i++) r[i] = 1'($urandom_range(0, 1));
    r[XLEN+179:XLEN+168] = 12'(csr);
    return r;
  endfunction

  function automatic int rand_csr();
    int sel = $urandom_range(0, 5);
    if (sel == 4) return 7;
    if (sel == 5) return $urandom_range(0, 4095);
    return sel;
  endfunction

  // Expected beats: the record's first L/8 bytes packed four per beat, little-endian.
  task automatic expect_rec(input logic [RVVI_W-1:0] r, output int nbeats);
    int n, nbytes;
    logic [7:0] bytes[$];
    beat_t b;
    n = int'(r[XLEN+179:XLEN+168]);
    if (n > MAX_CSRS) n = MAX_CSRS;
    nbytes = (3*XLEN + 200 + n*(XLEN+16)) / 8;
    for (int k = 0; k < nbytes; k++) bytes.push_back(r[8*k +: 8]);
    nbeats = (nbytes + BEAT_W/8 - 1) / (BEAT_W/8);
    for (int bi = 0; bi < nbeats; bi++) begin
      b.data = '0;
      b.keep = '0;
      for (int j = 0; j < BEAT_W/8; j++) begin
        if (bi*(BEAT_W/8) + j < nbytes) begin
          b.data[8*j +: 8] = bytes[bi*(BEAT_W/8) + j];
          b.keep[j] = 1'b1;
        end
      end
      b.last = (bi == nbeats-1);
      sb.push_back(b);
    end
  endtask

  task automatic step();
    bit pop, push, drop;
    int nb;
    pop = 1'b0;
    nb = 0;
    if (!resetn) begin
      m_q.delete();
      sb.delete();
      m_send = 1'b0;
      m_beat = 0;
      m_dc = 0;
      m_ov = 1'b0;
    end else begin
      if (m_send && tready) pop = (m_beat == m_q[0] - 1);
      push = en && valid && (m_q.size() < DEPTH || pop);
      drop = en && valid && (m_q.size() == DEPTH) && !pop;
      if (push) expect_rec(rvvi, nb);
      if (clr) begin
        m_dc = 0;
        m_ov = 1'b0;
      end else if (drop) begin
        if (m_dc < 65535) m_dc++;
        m_ov = 1'b1;
      end
      if (m_send) begin
        if (tready) begin
          if (pop) begin
            void'(m_q.pop_front());
            m_beat = 0;
          end else m_beat++;
        end
        if (push) m_q.push_back(nb);
        if (pop) m_send = (m_q.size() > 0);
      end else begin
        m_send = (m_q.size() > 0);
        if (push) m_q.push_back(nb);
      end
    end
    @(posedge clk);
    #1;
    chk("tvalid", axis.TValid, m_send);
    chk("rvvi_stall", stall, (m_q.size() >= DEPTH-1));
    chk("drop_count", drop_cnt, m_dc);
    chk("overflow", ovf, m_ov);
  endtask

  task automatic cyc(bit v, int csr, bit r);
    valid = v;
    if (v) rvvi = make_rec(csr);
    tready = r;
    step();
  endtask

  task automatic drain();
    int i;
    valid = 1'b0;
    tready = 1'b1;
    i = 0;
    while ((m_q.size() > 0 || m_send) && i < 400) begin
      step();
      i++;
    end
    chk("drain_done", (m_q.size() > 0 || m_send), 0);
  endtask

  // Monitor: beat comparisons on handshake, and hold-stability across stalls.
  initial begin
    bit prev_stall = 1'b0;
    beat_t held, exp_b;
    forever begin
      @(negedge clk);
      if (prev_stall) begin
        chk("stall_tvalid", axis.TValid, 1);
        chk("stall_tdata", axis.TData, held.data);
        chk("stall_tkeep", axis.TKeep, held.keep);
        chk("stall_tlast", axis.TLast, held.last);
      end
      if (resetn && axis.TValid && axis.TReady) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          exp_b = sb.pop_front();
          chk("beat_data", axis.TData, exp_b.data);
          chk("beat_keep", axis.TKeep, exp_b.keep);
          chk("beat_last", axis.TLast, exp_b.last);
        end
      end
      prev_stall = resetn && axis.TValid && !axis.TReady;
      held.data = axis.TData;
      held.keep = axis.TKeep;
      held.last = axis.TLast;
    end
  end

  initial begin
    int csrs[4] = '{0, 1, 3, 7};
    int guard;
    resetn = 1'b0;
    en = 1'b1;
    valid = 1'b0;
    clr = 1'b0;
    tready = 1'b0;
    rvvi = '0;
    repeat (3) step();
    chk("reset_tdata", axis.TData, 0);
    chk("reset_tkeep", axis.TKeep, 0);
    chk("reset_tlast", axis.TLast, 0);
    resetn = 1'b1;

    // single records of each length class, sink always ready
    foreach (csrs[i]) begin
      cyc(1'b1, csrs[i], 1'b1);
      drain();
    end

    // sink stalls for five cycles mid-burst
    cyc(1'b1, 3, 1'b1);
    repeat (3) cyc(1'b0, 0, 1'b1);
    repeat (5) cyc(1'b0, 0, 1'b0);
    drain();

    // fill past capacity with the sink blocked
    repeat (5) cyc(1'b1, rand_csr(), 1'b0);
    chk("full_stall", stall, 1);
    chk("full_drop_count", drop_cnt, 1);
    chk("full_overflow", ovf, 1);
    clr = 1'b1;
    cyc(1'b0, 0, 1'b0);
    clr = 1'b0;
    chk("clear_drop_count", drop_cnt, 0);
    chk("clear_overflow", ovf, 0);
    drain();

    // back-to-back records
    cyc(1'b1, 0, 1'b1);
    cyc(1'b1, 1, 1'b1);
    drain();

    // push on the cycle the full FIFO pops its head
    repeat (4) cyc(1'b1, rand_csr(), 1'b0);
    guard = 0;
    while (!(m_send && m_q.size() > 0 && m_beat == m_q[0] - 1) && guard < 100) begin
      cyc(1'b0, 0, 1'b1);
      guard++;
    end
    cyc(1'b1, 2, 1'b1);
    chk("full_pop_push_no_drop", drop_cnt, 0);
    drain();

    // reset mid-burst with two records queued
    cyc(1'b1, 3, 1'b1);
    cyc(1'b1, 3, 1'b1);
    repeat (2) cyc(1'b0, 0, 1'b1);
    resetn = 1'b0;
    cyc(1'b0, 0, 1'b0);
    resetn = 1'b1;
    chk("reset_mid_tvalid", axis.TValid, 0);
    chk("reset_mid_stall", stall, 0);
    cyc(1'b1, 1, 1'b1);
    drain();

    // capture disabled while full: no push, no drop
    repeat (4) cyc(1'b1, rand_csr(), 1'b0);
    en = 1'b0;
    repeat (3) cyc(1'b1, rand_csr(), 1'b0);
    chk("en_off_drop_count", drop_cnt, 0);
    en = 1'b1;
    drain();

    // random traffic
    repeat (700) begin
      en = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 40) == 0);
      cyc(1'($urandom_range(0, 1)), rand_csr(), 1'($urandom_range(0, 3) != 0));
    end
    en = 1'b1;
    clr = 1'b0;
    drain();
    repeat (2) step();
    chk("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rvvi_stream_packetizer.md
Name: rvvi_stream_packetizer

Overview:
- Takes one compressed rvvi record per retired instruction or trap from the synthesizable rvvi bridge.
- Buffers records in a DEPTH-entry FIFO.
- Serializes each record as a variable-length AXI-Stream-style burst of BEAT_W-bit beats. Only the CSR slots actually populated are sent.
- Sits between the rvvi bridge and the off-chip trace transmitter (Ethernet MAC or debug FIFO). Returns a stall request to the core pipeline.

Parameters:
- XLEN, 64, architectural register width; matches P.XLEN of the bridge.
- MAX_CSRS, 3, CSR slots in the incoming record.
- BEAT_W, 32, output beat width in bits; a multiple of 8, ≥32.
- DEPTH, 4, FIFO entries; a power of 2, ≥2.
- RVVI_W, 3*XLEN+200+MAX_CSRS*(XLEN+16), derived input record width.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- En  in  1  capture enable; when 0, records are ignored and not counted as drops
- valid  in  1  rvvi record valid this cycle
- rvvi  in  RVVI_W  record. Bit 0 upward: PC(XLEN), Instr(32), Mcycle(64), Minstret(64), Trap, Mode(2), GPRWen, FPRWen, 3 pad, CSRCount(12) at [XLEN+179:XLEN+168], 4 pad, Registers(2*XLEN+16), CSR slots(XLEN+16 each).
- RvviStall  out  1  back-pressure request to the core
- TData  out  BEAT_W  beat data
- TKeep  out  BEAT_W/8  byte enables
- TLast  out  1  final beat of the record
- TValid  out  1  beat valid
- TReady  in  1  sink accepts the beat
- DropCount  out  16  saturating count of lost records
- Overflow  out  1  sticky drop flag
- ClearOverflow  in  1  clears Overflow and DropCount

Behaviour:
- Reset (resetn=0 at a rising edge): FIFO empty, FSM to IDLE, beat index 0, TValid=0, TLast=0, TData=0, TKeep=0, DropCount=0, Overflow=0, RvviStall=0. Reset mid-burst abandons the burst; no further beats of it are sent.
- Push condition: En & valid & (~full | popping this cycle). Each entry stores rvvi plus a beat count.
  - N = min(CSRCount, MAX_CSRS).
  - Record bits L = 3*XLEN+200+N*(XLEN+16).
  - Beats = ceil(L/BEAT_W).
  - Last-beat bytes = ((L mod BEAT_W)/8), or BEAT_W/8 when the remainder is 0.
- Drop condition: En & valid & full & ~pop. Record is discarded, DropCount increments (saturates at 0xFFFF), Overflow set to 1. ClearOverflow has priority over a same-cycle drop.
- RvviStall = (occupancy ≥ DEPTH-1), derived from the registered occupancy.
- FSM states:
  - IDLE: TValid=0. If FIFO is non-empty, go to SEND with beat index 0. The first beat appears at least 1 cycle after the push edge; latency is exactly 1 when idle.
  - SEND:
    - Output signals: TValid=1; TData = head[idx*BEAT_W +: BEAT_W], zero-padded beyond L; TKeep=all ones except on the last beat; TLast=(idx==Beats-1).
    - TValid & ~TReady: TData, TKeep and TLast held stable.
    - Handshake, not last beat: idx++.
    - Handshake on last beat: pop the head, idx=0. Stay in SEND if the FIFO is non-empty after the pop (counting a same-cycle push), giving back-to-back records with no bubble; otherwise go to IDLE.
- Occupancy: push+pop in the same cycle leaves the count unchanged; the wrap of the read and write pointers is natural at DEPTH.
- Records are emitted strictly in arrival order. CSR slots beyond N are never transmitted.

Test Plan:
- XLEN=64, BEAT_W=32, CSRCount=0 record, TReady=1 → 13 beats (L=392); beat 0 = PC[31:0]; beat 12 TKeep=4'b0001, TLast=1; TValid first seen 1 cycle after push.
- CSRCount=1 → 15 beats, last TKeep=4'b0111. CSRCount=3 → 20 beats, last TKeep=4'b0111. CSRCount=7 → clamped to 3, 20 beats.
- TReady low for 5 cycles mid-burst → TData, TKeep and TLast stable through the stall; the beat index advances only on handshake.
- DEPTH=4, TReady=0, push 5 records → RvviStall rises when occupancy reaches 3; 5th record dropped, DropCount=1, Overflow=1. Pulse ClearOverflow → both 0. Then TReady=1 → 4 records drain in order.
- Back-to-back: two records queued, TReady=1 → the second record's beat 0 directly follows the first's TLast with no idle cycle. Push on the same cycle as the last-beat pop while full → accepted, no drop.
- resetn low mid-burst with 2 records queued → next cycle TValid=0, FIFO empty. A new record after resetn is released starts at beat 0. En=0 with valid → no push, DropCount unchanged.
